// File: rtl/cs_dac_tx_if.sv
// Sample-pair handshake between the audio source and the serial DAC transmitter.
interface cs_dac_tx_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_left, output in_right, output in_valid, input in_ready);
  modport slave  (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/cs_dac_tx.sv
// CS4344-class serial audio transmitter: one-pair holding register feeding an
// I2S / left-justified serializer that masters lrck/sclk from the system clock.
module cs_dac_tx #(
  parameter int DATA_W = 24,
  parameter int DIV    = 2
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       en,
  input  logic       i2s_lj_,
  cs_dac_tx_if.slave bus,
  output logic       underrun,
  output logic       lrck,
  output logic       sclk,
  output logic       sdata
);
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0]          div_cnt, div_cnt_nxt;
  logic [5:0]             slot, slot_inc, bit_slot;
  logic [4:0]             bit_idx;
  logic                   tick, fall_ev, frame_start;
  logic                   fmt, fmt_nxt;
  logic                   sclk_nxt, lrck_nxt, sdata_nxt;
  logic                   hold_full, xfer;
  logic [1:0][DATA_W-1:0] hold;
  logic [1:0]             ch_bit;

  assign tick        = en && (div_cnt == DIV_LAST);
  assign fall_ev     = tick && sclk;
  assign slot_inc    = slot + 6'd1;
  assign frame_start = fall_ev && (slot_inc == 6'd0);
  assign fmt_nxt     = frame_start ? i2s_lj_ : fmt;

  // I2S shifts the data one slot late, so it reads the bit of the slot being left.
  assign bit_slot = fmt_nxt ? slot : slot_inc;
  assign bit_idx  = ~bit_slot[4:0];

  // ---------------- holding register / handshake ----------------
  assign xfer         = bus.in_valid && !hold_full;
  assign bus.in_ready = !hold_full;

  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else begin
      if (xfer) hold <= {bus.in_right, bus.in_left};
      // A pair accepted on the frame-start edge survives the load of the old content.
      if (frame_start) hold_full <= xfer;
      else if (xfer)   hold_full <= 1'b1;
    end

  // ---------------- per-channel shift words (0 = left, 1 = right) ----------------
  for (genvar c = 0; c < 2; c++) begin : g_chan
    logic [31:0] word, word_nxt;

    always_comb begin
      word_nxt = word;
      if (frame_start) word_nxt = hold_full ? (32'(hold[c]) << (32 - DATA_W)) : '0;
    end

    always_ff @(posedge clk or negedge reset_)
      if (!reset_)  word <= '0;
      else if (!en) word <= '0;
      else          word <= word_nxt;

    // Read the post-load word so the MSB lands on the frame-start fall itself.
    assign ch_bit[c] = word_nxt[bit_idx];
  end

  // ---------------- serial clock / slot sequencing ----------------
  always_comb begin
    div_cnt_nxt = tick ? '0 : div_cnt + CW'(1);
    sclk_nxt    = tick ? ~sclk : sclk;
    lrck_nxt    = lrck;
    sdata_nxt   = sdata;
    if (fall_ev) begin
      sdata_nxt = (fmt_nxt && slot_inc == 6'd0) ? 1'b0 : ch_bit[bit_slot[5]];
      if (slot_inc[4:0] == 5'd0) lrck_nxt = slot_inc[5] ? fmt_nxt : ~fmt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      div_cnt  <= '0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      slot     <= 6'd63;
      fmt      <= 1'b0;
      underrun <= 1'b0;
    end else if (!en) begin
      // Park exactly as after reset so re-enable replays post-reset timing.
      div_cnt  <= '0;
      sclk     <= 1'b0;
      lrck     <= 1'b0;
      sdata    <= 1'b0;
      slot     <= 6'd63;
      fmt      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      div_cnt  <= div_cnt_nxt;
      sclk     <= sclk_nxt;
      lrck     <= lrck_nxt;
      sdata    <= sdata_nxt;
      fmt      <= fmt_nxt;
      underrun <= frame_start && !hold_full;
      if (fall_ev) slot <= slot_inc;
    end
endmodule
